// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: 640x480@60 pixel timing, sync generation and registered DAC drive.
// Optional build macro VGA_TEST_PATTERN_EN adds a test_mode input that replaces RGB with 8 colour bars.
module vga_timing_ctrl #(
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst,
`ifdef VGA_TEST_PATTERN_EN
   input  logic       test_mode,
`endif
   output logic [9:0] x,
   output logic [9:0] y,
   input  logic [7:0] red_in,
   input  logic [7:0] green_in,
   input  logic [7:0] blue_in,
   output logic       frame_start,
   output logic       vga_clk,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b,
   output logic       hsync_n,
   output logic       vsync_n,
   output logic       blank_n,
   output logic       sync_n
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_next;
   logic             pix_en;
   logic [9:0]       h_cnt;
   logic [9:0]       v_cnt;
   logic             active;
   logic             hs_next;
   logic             vs_next;
   logic [7:0]       r_next;
   logic [7:0]       g_next;
   logic [7:0]       b_next;

`ifdef VGA_TEST_PATTERN_EN
   localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
   logic [2:0] bar;
   assign bar = 3'(h_cnt / BAR_W);
`endif

   assign pix_en   = (div_cnt == DIV_LAST);
   assign div_next = pix_en ? '0 : div_cnt + 1'b1;

   // vga_clk is driven from the next divider value so the register output matches div_cnt
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         vga_clk <= 1'b0;
      end else begin
         div_cnt <= div_next;
         vga_clk <= (div_next >= DIV_HALF);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_en) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end
      end
   end

   assign x           = h_cnt;
   assign y           = v_cnt;
   assign frame_start = pix_en && (h_cnt == 10'd0) && (v_cnt == 10'd0);
   assign sync_n      = 1'b1;

   always_comb begin
      active  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      hs_next = !((h_cnt >= HS_START) && (h_cnt <= HS_END));
      vs_next = !((v_cnt >= VS_START) && (v_cnt <= VS_END));
      r_next  = 8'h00;
      g_next  = 8'h00;
      b_next  = 8'h00;
      if (active) begin
`ifdef VGA_TEST_PATTERN_EN
         if (test_mode) begin
            r_next = {8{bar[2]}};
            g_next = {8{bar[1]}};
            b_next = {8{bar[0]}};
         end else begin
            r_next = red_in;
            g_next = green_in;
            b_next = blue_in;
         end
`else
         r_next = red_in;
         g_next = green_in;
         b_next = blue_in;
`endif
      end
   end

   // One shared register stage keeps syncs, blanking and colour aligned at the DAC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vga_r   <= 8'h00;
         vga_g   <= 8'h00;
         vga_b   <= 8'h00;
         hsync_n <= 1'b1;
         vsync_n <= 1'b1;
         blank_n <= 1'b0;
      end else if (pix_en) begin
         vga_r   <= r_next;
         vga_g   <= g_next;
         vga_b   <= b_next;
         hsync_n <= hs_next;
         vsync_n <= vs_next;
         blank_n <= active;
      end
   end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Testbench for vga_timing_ctrl: random RGB against a pixel-index model, plus directed timing points.
// A shortened vertical frame keeps full frames within a short run; horizontal timing is the real 800.
module tb_vga_timing_ctrl;

   localparam int CD  = 2;
   localparam int HA  = 640;
   localparam int HFP = 16;
   localparam int HS  = 96;
   localparam int HBP = 48;
   localparam int VA  = 12;
   localparam int VFP = 2;
   localparam int VS  = 2;
   localparam int VBP = 2;
   localparam int HT  = HA + HFP + HS + HBP;
   localparam int VT  = VA + VFP + VS + VBP;

   logic       clk = 1'b0;
   logic       rst;
   logic       test_mode;
   logic [7:0] red_in;
   logic [7:0] green_in;
   logic [7:0] blue_in;
   logic [9:0] x;
   logic [9:0] y;
   logic       frame_start;
   logic       vga_clk;
   logic [7:0] vga_r;
   logic [7:0] vga_g;
   logic [7:0] vga_b;
   logic       hsync_n;
   logic       vsync_n;
   logic       blank_n;
   logic       sync_n;

   int total = 0;
   int bad   = 0;
   int drive_mode = 0;
   int edges = 0;
   logic [7:0] cap_r, cap_g, cap_b;
   logic       cap_tm;

   vga_timing_ctrl #(
      .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
   ) dut (
      .clk(clk),
      .rst(rst),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode(test_mode),
`endif
      .x(x),
      .y(y),
      .red_in(red_in),
      .green_in(green_in),
      .blue_in(blue_in),
      .frame_start(frame_start),
      .vga_clk(vga_clk),
      .vga_r(vga_r),
      .vga_g(vga_g),
      .vga_b(vga_b),
      .hsync_n(hsync_n),
      .vsync_n(vsync_n),
      .blank_n(blank_n),
      .sync_n(sync_n)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h want=%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Clock edges since reset release, and the inputs present at each pixel-enable edge
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         edges <= 0;
      end else begin
         if ((edges % CD) == CD - 1) begin
            cap_r  <= red_in;
            cap_g  <= green_in;
            cap_b  <= blue_in;
            cap_tm <= test_mode;
         end
         edges <= edges + 1;
      end
   end

   // Model: pixel index p = edges/CD gives (h,v); pins show pixel p-1
   always @(negedge clk) begin
      int div, p, q, eh, ev, qh, qv, k;
      logic [9:0]  ex, ey;
      logic [23:0] erg;
      logic [2:0]  esb;
      logic [1:0]  efc;
      logic        act;
      if (rst) begin
         ex = 10'd0; ey = 10'd0; erg = 24'h0; esb = 3'b110; efc = 2'b00;
      end else begin
         div = edges % CD;
         p   = edges / CD;
         eh  = p % HT;
         ev  = (p / HT) % VT;
         ex  = 10'(eh);
         ey  = 10'(ev);
         efc = {(div == CD - 1) && (eh == 0) && (ev == 0), div >= CD / 2};
         if (p == 0) begin
            erg = 24'h0; esb = 3'b110;
         end else begin
            q   = p - 1;
            qh  = q % HT;
            qv  = (q / HT) % VT;
            act = (qh < HA) && (qv < VA);
            if (!act) erg = 24'h0;
            else if (cap_tm) begin
               k   = qh / (HA / 8);
               erg = {(k[2] ? 8'hFF : 8'h00), (k[1] ? 8'hFF : 8'h00), (k[0] ? 8'hFF : 8'h00)};
            end else erg = {cap_r, cap_g, cap_b};
            esb = {!((qh >= HA + HFP) && (qh < HA + HFP + HS)),
                   !((qv >= VA + VFP) && (qv < VA + VFP + VS)), act};
         end
      end
      checkOutput("xy", {x, y}, {ex, ey});
      checkOutput("rgb", {vga_r, vga_g, vga_b}, erg);
      checkOutput("hs_vs_blank", {hsync_n, vsync_n, blank_n}, esb);
      checkOutput("fs_vclk_sync", {frame_start, vga_clk, sync_n}, {efc, 1'b1});
   end

   task automatic applyStimulus();
      @(negedge clk);
      red_in   = 8'($urandom);
      green_in = 8'($urandom);
      blue_in  = 8'($urandom);
      if (drive_mode == 1) begin
         red_in = 8'hFF; green_in = 8'h00; blue_in = 8'hFF; test_mode = 1'b0;
      end else if (drive_mode == 2) begin
         test_mode = 1'b1;
      end else begin
`ifdef VGA_TEST_PATTERN_EN
         test_mode = 1'($urandom_range(0, 1));
`else
         test_mode = 1'b0;
`endif
      end
   endtask

   task automatic waitFor(input int tx, input int ty, input string name);
      int n = 0;
      do begin
         applyStimulus();
         n++;
      end while (!((x == 10'(tx)) && (y == 10'(ty))) && n < 40000);
      if (!((x == 10'(tx)) && (y == 10'(ty)))) begin
         total++;
         bad++;
         $display("[TB] FAIL %s: timeout, got x=%0d y=%0d want x=%0d y=%0d", name, x, y, tx, ty);
      end
   endtask

   initial begin
      rst = 1'b1; red_in = 8'h00; green_in = 8'h00; blue_in = 8'h00; test_mode = 1'b0;
      repeat (3) applyStimulus();
      checkOutput("reset_pins", {x, y, vga_r, vga_g, vga_b, hsync_n, vsync_n, blank_n, vga_clk, frame_start},
                  {10'd0, 10'd0, 24'h0, 3'b110, 2'b00});
      rst = 1'b0;

      applyStimulus();
      checkOutput("rel_edge1", {x, vga_clk, frame_start}, {10'd0, 1'b1, 1'b1});
      applyStimulus();
      checkOutput("rel_edge2", {x, vga_clk, frame_start}, {10'd1, 1'b0, 1'b0});
      applyStimulus();
      applyStimulus();
      checkOutput("rel_edge4", x, 10'd2);

      waitFor(656, 0, "w656");  checkOutput("hs_655", hsync_n, 1'b1);
      waitFor(657, 0, "w657");  checkOutput("hs_656", hsync_n, 1'b0);
      waitFor(752, 0, "w752");  checkOutput("hs_751", hsync_n, 1'b0);
      waitFor(753, 0, "w753");  checkOutput("hs_752", hsync_n, 1'b1);

      drive_mode = 1;
      waitFor(640, 2, "w640");  checkOutput("col_639", {vga_r, vga_g, vga_b, blank_n}, {24'hFF00FF, 1'b1});
      waitFor(641, 2, "w641");  checkOutput("col_640", {vga_r, vga_g, vga_b, blank_n}, {24'h000000, 1'b0});
      waitFor(5, 11, "wv11");   checkOutput("col_v11", {vga_r, vga_g, vga_b, blank_n}, {24'hFF00FF, 1'b1});
      waitFor(5, 12, "wv12");   checkOutput("col_v12", {vga_r, vga_g, vga_b, blank_n}, {24'h000000, 1'b0});
      drive_mode = 0;

      waitFor(0, 14, "wvs0");   checkOutput("vs_13", vsync_n, 1'b1);
      waitFor(1, 14, "wvs1");   checkOutput("vs_14", vsync_n, 1'b0);
      waitFor(1, 15, "wvs2");   checkOutput("vs_15", vsync_n, 1'b0);
      waitFor(1, 16, "wvs3");   checkOutput("vs_16", vsync_n, 1'b1);

      waitFor(799, 17, "wlast");
      waitFor(0, 0, "wwrap");   checkOutput("wrap_fs_lo", frame_start, 1'b0);
      applyStimulus();          checkOutput("wrap_fs_hi", {x, y, frame_start}, {10'd0, 10'd0, 1'b1});
      applyStimulus();          checkOutput("wrap_next", {x, y, frame_start}, {10'd1, 10'd0, 1'b0});

      waitFor(300, 3, "wmid");
      applyStimulus();
      #1 rst = 1'b1;
      #1 checkOutput("mid_reset", {x, y, vga_r, vga_g, vga_b, hsync_n, vsync_n, blank_n, vga_clk, frame_start},
                     {10'd0, 10'd0, 24'h0, 3'b110, 2'b00});
      repeat (3) applyStimulus();
      rst = 1'b0;
      applyStimulus();
      applyStimulus();
      checkOutput("mid_rel", {x, y}, {10'd1, 10'd0});

`ifdef VGA_TEST_PATTERN_EN
      drive_mode = 2;
      waitFor(86, 10, "wtp85"); checkOutput("tp_85", {vga_r, vga_g, vga_b}, 24'h0000FF);
      waitFor(640, 10, "wtp639"); checkOutput("tp_639", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
      drive_mode = 0;
`endif

      repeat (2000) applyStimulus();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
